pe_lin_drain: RTL and testbench
===============================

# pe_lin_drain

Output drain for the linear PE array. It captures the array's `LANES`-wide result vector (`OW` bits per lane) on a capture strobe into a `DEPTH`-entry vector FIFO. It then serializes each stored vector lane by lane onto a valid/ready stream. It sits between the PE array's `outs` bus and the result writer or host interface, and is the consumer counterpart of the sequencer that drives `fire`/`in_a`.

## Interface
Parameters:
- `LANES`, default 4: number of PE outputs per vector.
- `OW`, default 12: bits per PE output.
- `DEPTH`, default 4: number of vector entries in the FIFO; power of two, ≥2.

Ports:
- `clk` in, 1: single clock; all logic on the posedge.
- `rstn` in, 1: reset, synchronous and active-low.
- `cap` in, 1: capture strobe; samples `in_o` at this edge.
- `in_o` in, `[0:LANES-1][OW-1:0]` (unpacked array): PE result vector.
- `m_valid` out, 1: output beat valid.
- `m_ready` in, 1: downstream accepts the beat.
- `m_data` out, `OW`: lane value.
- `m_lane` out, `$clog2(LANES)`: lane index of the current beat.
- `m_last` out, 1: high on lane `LANES-1`.
- `full` out, 1: high when count == `DEPTH`.
- `empty` out, 1: high when count == 0.
- `count` out, `$clog2(DEPTH)+1`: number of stored vectors.
- `ovf` out, 1: sticky overflow flag.
- `clr_ovf` in, 1: clears `ovf`.

## Operation
- Storage: `DEPTH` × `LANES` × `OW` register array, with write pointer `wp`, read pointer `rp` (each `$clog2(DEPTH)` bits, wrap modulo `DEPTH`), and a lane counter `ln`.
- Push: when `cap` && (!`full` || pop this cycle), write `in_o` to entry `wp` and increment `wp`.
- Drop: when `cap` && `full` && no pop this cycle, discard the vector and set `ovf`.
- Pop: a pop occurs when `m_valid` && `m_ready` && `ln` == `LANES-1`. It increments `rp` and resets `ln` to 0.
- Non-final accepted beat: `ln` increments.
- Push and pop in the same cycle: both take effect and `count` is unchanged. This holds at `full` (the capture is accepted, no overflow) and at `empty` (impossible, since pop requires `m_valid`).
- Output is a combinational mux of the head entry:
  - `m_data` = entry[`rp`][`ln`]
  - `m_lane` = `ln`
  - `m_last` = (`ln` == `LANES-1`)
  - `m_valid` = !`empty`
- Stability: while `m_valid` && !`m_ready`, `m_data`, `m_lane` and `m_last` hold stable. A capture never alters the head entry, because the write targets `wp`, which is never equal to `rp` unless the FIFO is empty, or full with a simultaneous pop.
- `ovf` control: `clr_ovf` clears it. If a set and a clear occur in the same cycle, the set wins.
- No arithmetic on data; values pass through bit-exact.

## Timing
- Reset (`rstn`=0 at a posedge): `wp`=`rp`=`ln`=0, `count`=0, `ovf`=0. This gives `m_valid`=0, `empty`=1, `full`=0, `m_lane`=0 and `m_last`=(`LANES`==1).
  - Storage contents are not reset; `m_data` is don't-care while `m_valid`=0.
  - A reset mid-stream abandons the partial vector and all stored vectors. `cap` is ignored during reset.
- Latency: with `cap` at edge k into an empty FIFO, `m_valid`=1 and `m_data`=`in_o[0]` are present in the cycle after edge k.
- Throughput: with `m_ready` held at 1, one beat per cycle and no bubble between vectors. A vector drains in `LANES` cycles.
- Sustained input: back-to-back `cap` every cycle fills the FIFO after `DEPTH` captures if the drain is slower. Steady state with no loss requires `cap` at most once per `LANES` cycles.
- Flags: `full`, `empty` and `count` reflect state after the most recent edge; they are registered-state derived with no combinational path from `cap`.
- Wrap-around: pointers wrap from `DEPTH-1` to 0 with no special handling.

## Test plan
- Single vector: after reset, `cap` with `in_o`={10,20,30,40} and `m_ready`=1 → the next 4 cycles show `m_data` 10,20,30,40, `m_lane` 0..3, `m_last` only on 40. `empty`=1 afterwards and `ovf`=0.
- Backpressure: same vector with `m_ready`=0 for 3 cycles, then toggling 1/0 → each value is held until accepted, no beat is duplicated or lost, and the order is 10,20,30,40.
- Fill/overflow: with `m_ready`=0, 5 captures of vectors {k,k+1,k+2,k+3}, k=0,4,8,12,16 → `full`=1 after the 4th capture. The 5th capture is dropped and `ovf`=1. Draining yields values 0..15 in order; `clr_ovf` clears `ovf`.
- Full with simultaneous pop: FIFO full, `m_ready`=1, and `cap` asserted on the cycle the last lane is accepted → `count` stays `DEPTH`, `ovf` stays 0, and the new vector appears last in the drain.
- Wrap: 10 sequential single-vector captures, each separated by ≥4 cycles, with `m_ready`=1 → every vector drains intact across the pointer wrap and `count` never exceeds 1.
- Reset mid-stream: 3 vectors stored and lane 2 of the first one pending, then `rstn`=0 for 1 cycle → `m_valid`=0, `count`=0 and `ovf`=0. A subsequent capture of {1,2,3,4} drains as 1,2,3,4 starting from lane 0.

Source files
------------

// File: rtl/pe_lin_drain.sv
// Result drain for the linear PE array: captures whole output vectors
// into a small vector FIFO and streams them out one lane per beat.
module pe_lin_drain #(
    parameter int LANES = 4,
    parameter int OW = 12,
    parameter int DEPTH = 4,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cap,
    input  logic [OW-1:0] in_o [0:LANES-1],
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data,
    output logic [LW-1:0] m_lane,
    output logic          m_last,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam logic [LW-1:0] LN_LAST = LW'(LANES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [OW-1:0] mem_q [0:DEPTH-1][0:LANES-1];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [LW-1:0] ln_q, ln_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic beat;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        beat = m_valid && m_ready;
        pop  = beat && (ln_q == LN_LAST);
        // A full FIFO still accepts a capture when its head leaves this cycle
        push = cap && (!full || pop);
        drop = cap && full && !pop;

        wp_d = push ? wp_q + AW'(1) : wp_q;
        rp_d = pop ? rp_q + AW'(1) : rp_q;

        ln_d = ln_q;
        if (pop) begin
            ln_d = '0;
        end else if (beat) begin
            ln_d = ln_q + LW'(1);
        end

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CW'(1);
        end

        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ln_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            ln_q  <= ln_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage is not reset; it is only observable once a vector is pushed
    always_ff @(posedge clk) begin
        if (rstn && push) begin
            for (int l = 0; l < LANES; l++) begin
                mem_q[wp_q][l] <= in_o[l];
            end
        end
    end

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign count   = cnt_q;
    assign ovf     = ovf_q;
    assign m_valid = !empty;
    assign m_data  = mem_q[rp_q][ln_q];
    assign m_lane  = ln_q;
    assign m_last  = (ln_q == LN_LAST);

endmodule

// File: tb/tb_pe_lin_drain.sv
// Directed bench for pe_lin_drain: vector table for single-vector and
// backpressure streaming, hand sequences for fill, wrap and reset cases.
module tb_pe_lin_drain;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cap;
    logic [11:0] in_o [0:3];
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic [1:0]  m_lane;
    logic        m_last;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        ovf;
    logic        clr_ovf;

    int checks = 0;
    int errors = 0;

    pe_lin_drain #(.LANES(4), .OW(12), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .cap(cap), .in_o(in_o),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_lane(m_lane), .m_last(m_last), .full(full),
        .empty(empty), .count(count), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cap, rdy, a, b, c, d;
        int v, dchk, data, lane, last, cnt, ovf;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic setv(int a, int b, int c, int d);
        in_o[0] = 12'(a);
        in_o[1] = 12'(b);
        in_o[2] = 12'(c);
        in_o[3] = 12'(d);
    endtask

    // Inputs change just after a falling edge; outputs are checked 1ns later
    task automatic drive(bit c, bit r, int a, int b, int cc, int d);
        @(negedge clk);
        cap = c;
        m_ready = r;
        setv(a, b, cc, d);
        #1;
    endtask

    task automatic beat(string nm, int data, int lane);
        chk({nm, "_valid"}, int'(m_valid), 1);
        chk({nm, "_data"}, int'(m_data), data);
        chk({nm, "_lane"}, int'(m_lane), lane);
        chk({nm, "_last"}, int'(m_last), (lane == 3) ? 1 : 0);
    endtask

    initial begin
        tbl[0]  = '{1, 1, 10, 20, 30, 40, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 1, 0};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 1, 1, 20, 1, 0, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 1, 1, 30, 2, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 0, 1, 1, 40, 3, 1, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 10, 20, 30, 40, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 0, 1, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 0, 1, 1, 10, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 20, 1, 0, 1, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 1, 1, 20, 1, 0, 1, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 30, 2, 0, 1, 0};
        tbl[14] = '{0, 1, 0, 0, 0, 0, 1, 1, 30, 2, 0, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 1, 40, 3, 1, 1, 0};
        tbl[16] = '{0, 1, 0, 0, 0, 0, 1, 1, 40, 3, 1, 1, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rstn = 1'b0;
        cap = 1'b0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        setv(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_lane", int'(m_lane), 0);
        chk("rst_last", int'(m_last), 0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].cap != 0, tbl[i].rdy != 0,
                  tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            chk($sformatf("tbl%0d_valid", i), int'(m_valid), tbl[i].v);
            chk($sformatf("tbl%0d_lane", i), int'(m_lane), tbl[i].lane);
            chk($sformatf("tbl%0d_last", i), int'(m_last), tbl[i].last);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_empty", i), int'(empty),
                (tbl[i].cnt == 0) ? 1 : 0);
            chk($sformatf("tbl%0d_ovf", i), int'(ovf), tbl[i].ovf);
            if (tbl[i].dchk != 0) begin
                chk($sformatf("tbl%0d_data", i), int'(m_data), tbl[i].data);
            end
        end

        // Fill to full with the drain stalled, then overflow
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 4*k, 4*k+1, 4*k+2, 4*k+3);
            chk($sformatf("fill%0d_count", k), int'(count), (k > 4) ? 4 : k);
            chk($sformatf("fill%0d_full", k), int'(full), (k == 4) ? 1 : 0);
            chk($sformatf("fill%0d_ovf", k), int'(ovf), 0);
        end
        drive(1'b1, 1'b0, 99, 99, 99, 99);
        clr_ovf = 1'b1;
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_count", int'(count), 4);
        chk("ovf_full", int'(full), 1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 0, 0, 0, 0);
            clr_ovf = 1'b0;
            if (i == 0) begin
                chk("ovf_setwins", int'(ovf), 1);
            end
            beat($sformatf("ovfdrain%0d", i), i, i % 4);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        clr_ovf = 1'b1;
        chk("ovfdrain_empty", int'(empty), 1);
        chk("ovfdrain_valid", int'(m_valid), 0);
        chk("ovf_sticky", int'(ovf), 1);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        clr_ovf = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);

        // Full FIFO accepts a capture on the cycle its head vector leaves
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 100+4*k, 101+4*k, 102+4*k, 103+4*k);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                drive(1'b1, 1'b1, 200, 201, 202, 203);
                chk("simpop_full_before", int'(full), 1);
            end else begin
                drive(1'b0, 1'b1, 0, 0, 0, 0);
            end
            if (i == 4) begin
                chk("simpop_count", int'(count), 4);
                chk("simpop_ovf", int'(ovf), 0);
            end
            beat($sformatf("simpop%0d", i),
                 (i < 16) ? 100 + i : 200 + i - 16, i % 4);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        chk("simpop_empty", int'(empty), 1);

        // Ten spaced single vectors walk the pointers through two wraps
        for (int v = 0; v < 10; v++) begin
            drive(1'b1, 1'b1, 16*v, 16*v+1, 16*v+2, 16*v+3);
            chk($sformatf("wrap%0d_idle", v), int'(m_valid), 0);
            for (int l = 0; l < 4; l++) begin
                drive(1'b0, 1'b1, 0, 0, 0, 0);
                beat($sformatf("wrap%0d_%0d", v, l), 16*v + l, l);
                chk($sformatf("wrap%0d_%0d_count", v, l), int'(count), 1);
            end
        end
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        chk("wrap_end_count", int'(count), 0);

        // Reset with three vectors queued and lane 2 of the head pending
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 50+4*k, 51+4*k, 52+4*k, 53+4*k);
        end
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        beat("rst_pending", 52, 2);
        chk("rst_pending_count", int'(count), 3);
        @(negedge clk);
        rstn = 1'b0;
        cap = 1'b1;
        m_ready = 1'b1;
        setv(77, 77, 77, 77);
        @(negedge clk);
        rstn = 1'b1;
        cap = 1'b1;
        setv(1, 2, 3, 4);
        #1;
        chk("midrst_valid", int'(m_valid), 0);
        chk("midrst_count", int'(count), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_lane", int'(m_lane), 0);
        for (int l = 0; l < 4; l++) begin
            drive(1'b0, 1'b1, 0, 0, 0, 0);
            beat($sformatf("postrst%0d", l), l + 1, l);
        end
        drive(1'b0, 1'b1, 0, 0, 0, 0);
        chk("postrst_empty", int'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
